// File: rtl/coreboot_ctrl_if.sv
// ZXUNO register-bus view of the core-boot controller, plus its sequencer-facing outputs.
// Pure wiring, no latency.
// No backpressure: register writes are level strobes and are edge-detected inside the controller.
interface coreboot_ctrl_if;
    logic [7:0]  zxuno_addr;
    logic        regaddr_changed;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic [23:0] spi_address;
    logic        reboot;
    logic        busy;

    // Bus master: the register-bus host, which also observes the sequencer outputs.
    modport master (
        output zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din,
        input  dout, oe, spi_address, reboot, busy
    );

    // Bus slave: the core-boot controller.
    modport slave (
        input  zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din,
        output dout, oe, spi_address, reboot, busy
    );
endinterface

// File: rtl/coreboot_ctrl.sv
// Key-guarded core-slot selector: computes the SPI flash address BASE + slot*SIZE and requests reboot.
// Latency: 1 cycle write-to-busy, 6 cycles address calculation, ARM_DELAY cycles arm, REBOOT_PULSE cycles pulse.
// No backpressure: writes arriving while busy are dropped. Optional COREBOOT_READBACK_EN streams spi_address on key reads.
module coreboot_ctrl #(
    parameter logic [7:0]  ADDR_CORESLOT = 8'hFC,
    parameter logic [7:0]  ADDR_COREKEY  = 8'hFD,
    parameter logic [23:0] SLOT_BASE     = 24'h058000,
    parameter logic [23:0] SLOT_SIZE     = 24'h054000,
    parameter logic [4:0]  MAX_SLOT      = 5'd24,
    parameter int          ARM_DELAY     = 16,
    parameter int          REBOOT_PULSE  = 4
) (
    input  logic           clk,
    input  logic           rst,
    coreboot_ctrl_if.slave bus
);

    localparam logic [7:0] KEY_FIRST  = 8'hA5;
    localparam logic [7:0] KEY_SECOND = 8'h5A;
    localparam logic [7:0] ARM_LAST   = 8'(ARM_DELAY - 1);
    localparam logic [7:0] PULSE_LAST = 8'(REBOOT_PULSE - 1);
    localparam logic [7:0] CALC_LAST  = 8'd5;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_KEY1     = 3'd1,
        S_UNLOCKED = 3'd2,
        S_CALC     = 3'd3,
        S_WAIT     = 3'd4,
        S_PULSE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic        err_q, err_d;
    logic [23:0] acc_q, acc_d;
    logic [23:0] spi_q, spi_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        slot_seen_q, slot_seen_d;
    logic        key_seen_q, key_seen_d;

    logic        sel_slot, sel_key;
    logic        chg_slot, chg_key;
    logic        slot_wr, key_wr;
    logic        busy_w;

    assign sel_slot = (bus.zxuno_addr == ADDR_CORESLOT);
    assign sel_key  = (bus.zxuno_addr == ADDR_COREKEY);
    assign chg_slot = bus.regaddr_changed & sel_slot;
    assign chg_key  = bus.regaddr_changed & sel_key;

    // A held write level counts once; an address rewrite (or moving away) re-arms the tracker,
    // and an address rewrite on the same cycle as a write suppresses that write.
    assign slot_seen_d = bus.zxuno_regwr & sel_slot & ~chg_slot;
    assign key_seen_d  = bus.zxuno_regwr & sel_key  & ~chg_key;
    assign slot_wr     = bus.zxuno_regwr & sel_slot & ~chg_slot & ~slot_seen_q;
    assign key_wr      = bus.zxuno_regwr & sel_key  & ~chg_key  & ~key_seen_q;

    assign busy_w = (state_q == S_CALC) || (state_q == S_WAIT) || (state_q == S_PULSE);

    // Write-edge trackers for both registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_seen_q <= 1'b0;
            key_seen_q  <= 1'b0;
        end else begin
            slot_seen_q <= slot_seen_d;
            key_seen_q  <= key_seen_d;
        end
    end

    // Controller state, latched slot/error, shift-add accumulator and shared cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOCKED;
            slot_q  <= 5'd0;
            err_q   <= 1'b0;
            acc_q   <= 24'd0;
            spi_q   <= SLOT_BASE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            spi_q   <= spi_d;
            cnt_q   <= cnt_d;
        end
    end

    // Unlock sequence, slot validation, MSB-first shift-add multiply, arm delay and reboot pulse.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        err_d   = err_q;
        acc_d   = acc_q;
        spi_d   = spi_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOCKED: begin
                if (key_wr && bus.din == KEY_FIRST) begin
                    state_d = S_KEY1;
                end
            end
            S_KEY1: begin
                if (key_wr) begin
                    if (bus.din == KEY_SECOND) begin
                        state_d = S_UNLOCKED;
                    end else if (bus.din != KEY_FIRST) begin
                        state_d = S_LOCKED;
                    end
                end else if (slot_wr) begin
                    state_d = S_LOCKED;
                end
            end
            S_UNLOCKED: begin
                if (slot_wr) begin
                    if (bus.din[7]) begin
                        if (bus.din[4:0] <= MAX_SLOT) begin
                            slot_d  = bus.din[4:0];
                            err_d   = 1'b0;
                            acc_d   = 24'd0;
                            cnt_d   = 8'd0;
                            state_d = S_CALC;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_LOCKED;
                        end
                    end else begin
                        // Slot preselect without launching a reboot; no range check needed here.
                        slot_d = bus.din[4:0];
                    end
                end else if (key_wr && bus.din != KEY_FIRST && bus.din != KEY_SECOND) begin
                    state_d = S_LOCKED;
                end
            end
            S_CALC: begin
                if (cnt_q != CALC_LAST) begin
                    // Bit 4 of the slot is consumed first so the accumulator doubles up to slot*SIZE.
                    acc_d = {acc_q[22:0], 1'b0} + (slot_q[3'd4 - cnt_q[2:0]] ? SLOT_SIZE : 24'd0);
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    spi_d   = acc_q + SLOT_BASE;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == ARM_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_LOCKED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_LOCKED;
                cnt_d   = 8'd0;
            end
        endcase
    end

    logic [7:0] key_rd_dat;

`ifdef COREBOOT_READBACK_EN
    logic [1:0] rb_ptr_q, rb_ptr_d;
    logic       rd_seen_q, rd_seen_d;
    logic       rd_rise;

    assign rd_seen_d = bus.zxuno_regrd & sel_key;
    assign rd_rise   = bus.zxuno_regrd & sel_key & ~rd_seen_q;

    // Readback byte pointer: restart on key-address rewrite, advance once per read strobe.
    always_comb begin
        rb_ptr_d = rb_ptr_q;
        if (chg_key) begin
            rb_ptr_d = 2'd0;
        end else if (rd_rise) begin
            rb_ptr_d = (rb_ptr_q == 2'd2) ? 2'd0 : rb_ptr_q + 2'd1;
        end
    end

    // Readback pointer and read-edge tracker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_ptr_q  <= 2'd0;
            rd_seen_q <= 1'b0;
        end else begin
            rb_ptr_q  <= rb_ptr_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    // Key register returns the flash address, high byte first.
    always_comb begin
        key_rd_dat = 8'h00;
        unique case (rb_ptr_q)
            2'd0:    key_rd_dat = spi_q[23:16];
            2'd1:    key_rd_dat = spi_q[15:8];
            default: key_rd_dat = spi_q[7:0];
        endcase
    end
`else
    // Key register returns the state encoding as status.
    always_comb begin
        key_rd_dat = {5'b0, state_q};
    end
`endif

    // Register read mux; read data is combinational on the currently selected address.
    always_comb begin
        bus.oe   = bus.zxuno_regrd & (sel_slot | sel_key);
        bus.dout = 8'h00;
        if (bus.zxuno_regrd && sel_slot) begin
            bus.dout = {busy_w, err_q, 1'b0, slot_q};
        end else if (bus.zxuno_regrd && sel_key) begin
            bus.dout = key_rd_dat;
        end
    end

    assign bus.spi_address = spi_q;
    assign bus.reboot      = (state_q == S_PULSE);
    assign bus.busy        = busy_w;

endmodule
